mem_responder: RTL

- Memory-side responder for the CPU datapath's memory bus.
- The control unit initiates reads (MAR loaded, Read asserted) and writes (MAR/MDR loaded, RAM_write asserted).
- This block services each request from an internal word-addressed RAM after a programmable number of wait states, then signals completion with a one-cycle Mem_ready pulse.
- Read data is returned on Mem_data_out for loading into MDR.

---
 rtl/mem_responder_if.sv | 26 ++
 rtl/mem_responder.sv | 107 ++++++++++
 2 files changed

// File: rtl/mem_responder_if.sv
// Memory request/response bus between the control unit and the memory responder.
interface mem_responder_if #(
   parameter int unsigned ADDR_WIDTH = 9,
   parameter int unsigned DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] MAR_addr;
   logic [DATA_WIDTH-1:0] MDR_wdata;
   logic                  Read;
   logic                  RAM_write;
   logic [DATA_WIDTH-1:0] Mem_data_out;
   logic                  Mem_ready;
   logic                  Busy;
   logic                  Protocol_err;

   // Requester side: drives the request, observes completion.
   modport master (
      output MAR_addr, MDR_wdata, Read, RAM_write,
      input  Mem_data_out, Mem_ready, Busy, Protocol_err
   );

   // Responder side: samples the request, drives completion.
   modport slave (
      input  MAR_addr, MDR_wdata, Read, RAM_write,
      output Mem_data_out, Mem_ready, Busy, Protocol_err
   );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: services word reads/writes from an internal RAM after a
// fixed number of wait states and signals completion with a one-cycle Mem_ready.
module mem_responder #(
   parameter int unsigned ADDR_WIDTH  = 9,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic            Clock,
   input  logic            Reset,
   mem_responder_if.slave  bus
);

   localparam int unsigned Depth  = 1 << ADDR_WIDTH;
   localparam logic [3:0]  WsInit = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {StIdle, StWait, StAccess, StDone} state_e;

   state_e                r_state;
   state_e                w_state_d;
   logic [3:0]            r_cnt;
   logic [3:0]            w_cnt_d;
   logic                  w_latch;
   logic                  w_perr_d;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_is_wr;
   logic [DATA_WIDTH-1:0] r_dout;
   logic                  r_ready;
   logic                  r_busy;
   logic                  r_perr;
   logic [DATA_WIDTH-1:0] r_mem [Depth];

   // Next-state logic; requests are only looked at while idle.
   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      w_latch   = 1'b0;
      w_perr_d  = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (bus.Read && bus.RAM_write) begin
               w_perr_d = 1'b1;
            end else if (bus.Read || bus.RAM_write) begin
               w_latch = 1'b1;
               if (WAIT_STATES > 0) begin
                  w_state_d = StWait;
                  w_cnt_d   = WsInit;
               end else begin
                  w_state_d = StAccess;
               end
            end
         end
         StWait: begin
            if (r_cnt == 4'd0) begin
               w_state_d = StAccess;
            end else begin
               w_cnt_d = r_cnt - 4'd1;
            end
         end
         StAccess: w_state_d = StDone;
         StDone:   w_state_d = StIdle;
         default:  w_state_d = StIdle;
      endcase
   end

   // State, request latches and registered outputs; reset aborts any access in flight.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_state <= StIdle;
         r_cnt   <= 4'd0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_is_wr <= 1'b0;
         r_dout  <= '0;
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
         r_perr  <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         r_ready <= (w_state_d == StDone);
         r_busy  <= (w_state_d != StIdle);
         r_perr  <= w_perr_d;
         if (w_latch) begin
            r_addr  <= bus.MAR_addr;
            r_wdata <= bus.MDR_wdata;
            r_is_wr <= bus.RAM_write;
         end
         if (r_state == StAccess && !r_is_wr) begin
            r_dout <= r_mem[r_addr];
         end
      end
   end

   // RAM array: never cleared; reset forces IDLE so an aborted write cannot land.
   always_ff @(posedge Clock) begin
      if (r_state == StAccess && r_is_wr) begin
         r_mem[r_addr] <= r_wdata;
      end
   end

   assign bus.Mem_data_out = r_dout;
   assign bus.Mem_ready    = r_ready;
   assign bus.Busy         = r_busy;
   assign bus.Protocol_err = r_perr;

endmodule
